// File: rtl/coffee_pkg.sv
// Shared types and helpers for the multi-product coffee vendor.
// Credit and prices are counted in quarter units throughout.
package coffee_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_e;

    localparam int Q025 = 1;
    localparam int Q05  = 2;
    localparam int Q1   = 4;

    // Widest packed price table the helper accepts (16 products x 32 bits).
    localparam int PRICES_MAX_W = 512;

    function automatic logic [31:0] price_of(input logic [PRICES_MAX_W-1:0] prices,
                                             input int idx, input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return 32'(prices >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/coffee_change_dispenser.sv
// Greedy coin-return generator: load a credit, then pay it out one coin per
// cycle using the largest coin that fits. Shared by refunds and change.
module coffee_change_dispenser
    import coffee_pkg::*;
#(
    parameter int PRICE_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [PRICE_W-1:0] load_credit,
    output logic [PRICE_W-1:0] remaining,
    output logic               change_1,
    output logic               change_05,
    output logic               change_025
);

    logic [PRICE_W-1:0] rem_q, rem_d;
    logic               change_1_q, change_1_d;
    logic               change_05_q, change_05_d;
    logic               change_025_q, change_025_d;

    always_comb begin
        rem_d        = rem_q;
        change_1_d   = 1'b0;
        change_05_d  = 1'b0;
        change_025_d = 1'b0;
        if (load) begin
            rem_d = load_credit;
        end else if (int'(rem_q) >= Q1) begin
            change_1_d = 1'b1;
            rem_d      = rem_q - PRICE_W'(Q1);
        end else if (int'(rem_q) >= Q05) begin
            change_05_d = 1'b1;
            rem_d       = rem_q - PRICE_W'(Q05);
        end else if (rem_q != '0) begin
            change_025_d = 1'b1;
            rem_d        = rem_q - PRICE_W'(Q025);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q        <= '0;
            change_1_q   <= 1'b0;
            change_05_q  <= 1'b0;
            change_025_q <= 1'b0;
        end else begin
            rem_q        <= rem_d;
            change_1_q   <= change_1_d;
            change_05_q  <= change_05_d;
            change_025_q <= change_025_d;
        end
    end

    assign remaining  = rem_q;
    assign change_1   = change_1_q;
    assign change_05  = change_05_q;
    assign change_025 = change_025_q;

endmodule

// File: rtl/coffee_vendor_multi.sv
// Multi-product coffee vendor: coin credit, per-product prices, refunds and
// change via the greedy dispenser, saturating vend counter.
module coffee_vendor_multi
    import coffee_pkg::*;
#(
    parameter int                            N_PRODUCTS = 4,
    parameter int                            PRICE_W    = 6,
    parameter logic [N_PRODUCTS*PRICE_W-1:0] PRICES     = {6'd8, 6'd6, 6'd5, 6'd4},
    parameter int                            COUNT_W    = 10,
    parameter bit                            AUTO_VEND  = 1'b0,
    localparam int                           SEL_W      = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               money_in025,
    input  logic               money_in05,
    input  logic               money_in1,
    input  logic               select_valid,
    input  logic [SEL_W-1:0]   product_sel,
    input  logic               cancel,
    output logic               sai_cafe,
    output logic [SEL_W-1:0]   product_out,
    output logic               change_025,
    output logic               change_05,
    output logic               change_1,
    output logic               coin_reject,
    output logic               sel_error,
    output logic [PRICE_W-1:0] credit,
    output logic               busy,
    output logic [COUNT_W-1:0] coffee_counter
);

    localparam int                        SUM_W      = PRICE_W + 3;
    localparam int                        CREDIT_MAX = (1 << PRICE_W) - 1;
    localparam logic [PRICES_MAX_W-1:0]   PRICES_EXT = PRICES_MAX_W'(PRICES);

    state_e             state_q, state_d;
    logic [PRICE_W-1:0] credit_q, credit_d;
    logic [COUNT_W-1:0] counter_q, counter_d;
    logic               sai_cafe_q, sai_cafe_d;
    logic [SEL_W-1:0]   product_out_q, product_out_d;
    logic               coin_reject_q, coin_reject_d;
    logic               sel_error_q, sel_error_d;
    logic               busy_q, busy_d;

    logic [2:0]         coin_sum;
    logic               any_coin, coins_fit, in_entry;
    logic [SUM_W-1:0]   credit_sum;
    logic [PRICE_W-1:0] sel_price, price0;
    logic               cancel_go, vend_go, sel_reject, auto_go;
    logic               disp_load;
    logic [PRICE_W-1:0] disp_load_credit, disp_remaining;

    assign coin_sum   = (money_in1   ? 3'(Q1)   : 3'd0)
                      + (money_in05  ? 3'(Q05)  : 3'd0)
                      + (money_in025 ? 3'(Q025) : 3'd0);
    assign any_coin   = money_in1 | money_in05 | money_in025;
    assign credit_sum = SUM_W'(credit_q) + SUM_W'(coin_sum);
    assign coins_fit  = credit_sum <= SUM_W'(CREDIT_MAX);
    assign sel_price  = PRICE_W'(price_of(PRICES_EXT, int'(product_sel), PRICE_W));
    assign price0     = PRICE_W'(price_of(PRICES_EXT, 0, PRICE_W));
    assign in_entry   = (state_q == IDLE) || (state_q == CREDIT);

    // Priority in IDLE/CREDIT: cancel, then select, then coins.
    assign cancel_go  = in_entry && cancel && (credit_q != '0);
    assign vend_go    = in_entry && !AUTO_VEND && !cancel_go && select_valid
                        && (int'(product_sel) < N_PRODUCTS) && (credit_q >= sel_price);
    assign sel_reject = in_entry && !AUTO_VEND && !cancel_go && select_valid && !vend_go;
    assign auto_go    = in_entry && AUTO_VEND && !cancel_go && any_coin && coins_fit
                        && (credit_sum >= SUM_W'(price0));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, CREDIT: begin
                if (cancel_go)
                    state_d = CHANGE;
                else if (vend_go || auto_go)
                    state_d = DISPENSE;
                else if ((coins_fit && credit_sum != '0) || credit_q != '0)
                    state_d = CREDIT;
                else
                    state_d = IDLE;
            end
            DISPENSE: state_d = (disp_remaining != '0) ? CHANGE : IDLE;
            CHANGE:   state_d = (disp_remaining == '0) ? IDLE : CHANGE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        credit_d         = credit_q;
        counter_d        = counter_q;
        sai_cafe_d       = 1'b0;
        product_out_d    = product_out_q;
        coin_reject_d    = any_coin;
        sel_error_d      = 1'b0;
        disp_load        = 1'b0;
        disp_load_credit = '0;
        busy_d           = (state_d == DISPENSE) || (state_d == CHANGE);
        unique case (state_q)
            IDLE, CREDIT: begin
                if (cancel_go) begin
                    disp_load        = 1'b1;
                    disp_load_credit = credit_q;
                    credit_d         = '0;
                end else if (vend_go) begin
                    sai_cafe_d       = 1'b1;
                    product_out_d    = product_sel;
                    disp_load        = 1'b1;
                    disp_load_credit = credit_q - sel_price;
                end else begin
                    sel_error_d   = sel_reject;
                    coin_reject_d = any_coin && !coins_fit;
                    if (coins_fit)
                        credit_d = credit_sum[PRICE_W-1:0];
                    if (auto_go) begin
                        sai_cafe_d       = 1'b1;
                        product_out_d    = '0;
                        disp_load        = 1'b1;
                        disp_load_credit = credit_sum[PRICE_W-1:0] - price0;
                    end
                end
            end
            DISPENSE: begin
                // Leftover credit already sits in the dispenser from the accept edge.
                credit_d  = '0;
                counter_d = (counter_q == '1) ? counter_q : counter_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            counter_q     <= '0;
            sai_cafe_q    <= 1'b0;
            product_out_q <= '0;
            coin_reject_q <= 1'b0;
            sel_error_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            counter_q     <= counter_d;
            sai_cafe_q    <= sai_cafe_d;
            product_out_q <= product_out_d;
            coin_reject_q <= coin_reject_d;
            sel_error_q   <= sel_error_d;
            busy_q        <= busy_d;
        end
    end

    coffee_change_dispenser #(
        .PRICE_W (PRICE_W)
    ) u_dispenser (
        .clock       (clock),
        .reset       (reset),
        .load        (disp_load),
        .load_credit (disp_load_credit),
        .remaining   (disp_remaining),
        .change_1    (change_1),
        .change_05   (change_05),
        .change_025  (change_025)
    );

    assign sai_cafe       = sai_cafe_q;
    assign product_out    = product_out_q;
    assign coin_reject    = coin_reject_q;
    assign sel_error      = sel_error_q;
    assign busy           = busy_q;
    assign coffee_counter = counter_q;
    assign credit         = (state_q == CHANGE) ? disp_remaining : credit_q;

endmodule

// File: tb/tb_coffee_vendor_multi.sv
// Bench for coffee_vendor_multi: three configurations share one stimulus bus,
// output pulses of the selected instance are scored against an event queue.
module tb_coffee_vendor_multi;

    localparam int EV_VEND = 16;
    localparam int EV_C1   = 33;
    localparam int EV_C05  = 34;
    localparam int EV_C025 = 35;
    localparam int EV_REJ  = 48;
    localparam int EV_SEL  = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       m025, m05, m1, sel_v, cancel;
    logic [1:0] psel;

    // per-instance outputs: 0 = default, 1 = legacy auto-vend, 2 = small widths
    logic       sai0, sai1, sai2;
    logic [1:0] prod0, prod1, prod2;
    logic       c1_0, c1_1, c1_2, c05_0, c05_1, c05_2, c025_0, c025_1, c025_2;
    logic       rej0, rej1, rej2, se0, se1, se2, busy0, busy1, busy2;
    logic [5:0] credit0, credit1;
    logic [3:0] credit2;
    logic [9:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int dsel = 0;
    logic m_sai, m_c1, m_c05, m_c025, m_rej, m_se, m_busy;
    int   m_prod, m_credit, m_cnt;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    coffee_vendor_multi u_std (
        .clock(clk), .reset(reset), .money_in025(m025), .money_in05(m05), .money_in1(m1),
        .select_valid(sel_v), .product_sel(psel), .cancel(cancel),
        .sai_cafe(sai0), .product_out(prod0), .change_025(c025_0), .change_05(c05_0),
        .change_1(c1_0), .coin_reject(rej0), .sel_error(se0), .credit(credit0),
        .busy(busy0), .coffee_counter(cnt0));

    coffee_vendor_multi #(.AUTO_VEND(1'b1)) u_leg (
        .clock(clk), .reset(reset), .money_in025(m025), .money_in05(m05), .money_in1(m1),
        .select_valid(sel_v), .product_sel(psel), .cancel(cancel),
        .sai_cafe(sai1), .product_out(prod1), .change_025(c025_1), .change_05(c05_1),
        .change_1(c1_1), .coin_reject(rej1), .sel_error(se1), .credit(credit1),
        .busy(busy1), .coffee_counter(cnt1));

    coffee_vendor_multi #(.N_PRODUCTS(3), .PRICE_W(4), .PRICES(12'h321), .COUNT_W(2)) u_sml (
        .clock(clk), .reset(reset), .money_in025(m025), .money_in05(m05), .money_in1(m1),
        .select_valid(sel_v), .product_sel(psel), .cancel(cancel),
        .sai_cafe(sai2), .product_out(prod2), .change_025(c025_2), .change_05(c05_2),
        .change_1(c1_2), .coin_reject(rej2), .sel_error(se2), .credit(credit2),
        .busy(busy2), .coffee_counter(cnt2));

    always_comb begin
        m_sai = sai0; m_c1 = c1_0; m_c05 = c05_0; m_c025 = c025_0;
        m_rej = rej0; m_se = se0; m_busy = busy0;
        m_prod = int'(prod0); m_credit = int'(credit0); m_cnt = int'(cnt0);
        if (dsel == 1) begin
            m_sai = sai1; m_c1 = c1_1; m_c05 = c05_1; m_c025 = c025_1;
            m_rej = rej1; m_se = se1; m_busy = busy1;
            m_prod = int'(prod1); m_credit = int'(credit1); m_cnt = int'(cnt1);
        end else if (dsel == 2) begin
            m_sai = sai2; m_c1 = c1_2; m_c05 = c05_2; m_c025 = c025_2;
            m_rej = rej2; m_se = se2; m_busy = busy2;
            m_prod = int'(prod2); m_credit = int'(credit2); m_cnt = int'(cnt2);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_event(input string tag, input int code);
        int e;
        e = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
        check_eq(tag, code, e);
    endtask

    // Every output pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (m_rej)  expect_event("coin_reject", EV_REJ);
        if (m_se)   expect_event("sel_error", EV_SEL);
        if (m_sai)  expect_event("sai_cafe", EV_VEND + m_prod);
        if (m_c1)   expect_event("change_1", EV_C1);
        if (m_c05)  expect_event("change_05", EV_C05);
        if (m_c025) expect_event("change_025", EV_C025);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m025 = 0; m05 = 0; m1 = 0; sel_v = 0; cancel = 0; psel = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic check_idle(input string tag, input int cnt);
        check_eq({tag, "_credit"}, m_credit, 0);
        check_eq({tag, "_busy"}, m_busy, 0);
        check_eq({tag, "_count"}, m_cnt, cnt);
        check_eq({tag, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        #12;
        check_eq("rst_sai", m_sai, 0);
        check_eq("rst_prod", m_prod, 0);
        check_eq("rst_credit", m_credit, 0);
        check_eq("rst_count", m_cnt, 0);
        check_eq("rst_busy", m_busy, 0);
        check_eq("rst_change", {m_c1, m_c05, m_c025, m_rej, m_se}, 0);

        // Legacy auto-vend: quarter held four cycles.
        dsel = 1;
        do_reset();
        m025 = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq("leg_credit", m_credit, i);
        end
        exp_q.push_back(EV_VEND + 0);
        tick();
        m025 = 0;
        check_eq("leg_credit4", m_credit, 4);
        check_eq("leg_busy", m_busy, 1);
        tick();
        tick();
        check_idle("leg_done", 1);

        // Vend product 1 (price 5) from 8 quarters: 3 quarters of change.
        dsel = 0;
        do_reset();
        m1 = 1;
        tick();
        tick();
        m1 = 0;
        check_eq("chg_credit8", m_credit, 8);
        exp_q.push_back(EV_VEND + 1);
        exp_q.push_back(EV_C05);
        exp_q.push_back(EV_C025);
        sel_v = 1; psel = 2'd1;
        tick();
        sel_v = 0;
        check_eq("chg_busy", m_busy, 1);
        tick();
        check_eq("chg_credit1", m_credit, 1);
        tick();
        check_eq("chg_credit0", m_credit, 0);
        tick();
        check_idle("chg_done", 1);

        // Insufficient credit for product 3, with and without a coin alongside.
        m1 = 1;
        tick();
        m1 = 0;
        exp_q.push_back(EV_SEL);
        sel_v = 1; psel = 2'd3;
        tick();
        check_eq("ins_credit", m_credit, 4);
        exp_q.push_back(EV_SEL);
        m025 = 1;
        tick();
        sel_v = 0; m025 = 0;
        tick();
        check_eq("ins_coin_credit", m_credit, 5);
        check_eq("ins_queue", exp_q.size(), 0);

        // Cancel beats select and coins in the same cycle.
        do_reset();
        m05 = 1; m025 = 1;
        tick();
        m05 = 0; m025 = 0;
        check_eq("can_credit3", m_credit, 3);
        exp_q.push_back(EV_REJ);
        exp_q.push_back(EV_C05);
        exp_q.push_back(EV_C025);
        cancel = 1; sel_v = 1; psel = 2'd0; m1 = 1;
        tick();
        idle_inputs();
        repeat (3) tick();
        check_idle("can_done", 0);

        // Credit register overflow at PRICE_W=4.
        dsel = 2;
        do_reset();
        m1 = 1;
        repeat (3) tick();
        m1 = 0; m05 = 1;
        tick();
        m05 = 0;
        check_eq("ovf_credit14", m_credit, 14);
        m025 = 1;
        tick();
        check_eq("ovf_credit15", m_credit, 15);
        exp_q.push_back(EV_REJ);
        tick();
        m025 = 0;
        check_eq("ovf_hold15", m_credit, 15);
        tick();
        check_eq("ovf_queue", exp_q.size(), 0);

        // Counter saturation at COUNT_W=2, then an out-of-range select.
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            m025 = 1;
            tick();
            m025 = 0;
            exp_q.push_back(EV_VEND + 0);
            sel_v = 1; psel = 2'd0;
            tick();
            sel_v = 0;
            tick();
            check_eq("sat_count", m_cnt, (v < 3) ? v : 3);
        end
        m025 = 1;
        tick();
        m025 = 0;
        exp_q.push_back(EV_SEL);
        sel_v = 1; psel = 2'd3;
        tick();
        sel_v = 0;
        tick();
        check_eq("oor_credit", m_credit, 1);
        check_eq("oor_queue", exp_q.size(), 0);

        // Asynchronous reset in the middle of paying out change.
        dsel = 0;
        do_reset();
        m1 = 1;
        repeat (3) tick();
        m1 = 0;
        exp_q.push_back(EV_VEND + 2);
        sel_v = 1; psel = 2'd2;
        tick();
        sel_v = 0;
        tick();
        check_eq("ar_change1", m_c1, 1);
        check_eq("ar_credit2", m_credit, 2);
        #2 reset = 1'b0;
        #1;
        check_eq("ar_pulses", {m_sai, m_c1, m_c05, m_c025, m_rej, m_se}, 0);
        check_eq("ar_credit", m_credit, 0);
        check_eq("ar_count", m_cnt, 0);
        check_eq("ar_busy", m_busy, 0);
        tick();
        tick();
        #2 reset = 1'b1;
        tick();
        tick();
        m1 = 1;
        tick();
        m1 = 0;
        exp_q.push_back(EV_VEND + 0);
        sel_v = 1; psel = 2'd0;
        tick();
        sel_v = 0;
        tick();
        tick();
        check_idle("ar_revend", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
